game_renderer: RTL and testbench
================================

// Module: game_renderer
// PURPOSE
//  Per-pixel colour generator and game-state controller for the VGA game. Sits between the
//  sync/pixel counter (x,y) and the RGB pins. Draws one player and NUM_ENEMIES enemy sprites,
//  and detects pixel-accurate player/enemy overlap. Sequences IDLE -> PLAYING -> DEAD, and
//  DEAD returns to IDLE on a button press, with no reset needed.
// PARAMETERS
//  COORD_W      16   width of all x/y coordinates
//  NUM_ENEMIES  4    enemy sprite count (1..8)
//  SPRITE_W     60   sprite width in pixels (player and enemies)
//  SPRITE_H     60   sprite height in pixels
//  COLOR_W      4    bits per colour channel
//  H_ACT_START  144  active window: x > H_ACT_START && x <= H_ACT_END
//  H_ACT_END    783
//  V_ACT_START  35   active window: y > V_ACT_START && y <= V_ACT_END
//  V_ACT_END    514
//  GROUND_H     20   height of top and bottom green bands inside the active window
//  SYNC_STAGES  2    button synchroniser depth (>=2)
// PORTS
//  clk        in   1                  pixel clock
//  reset      in   1                  asynchronous, active-low
//  x, y       in   COORD_W            current pixel position
//  x_player   in   COORD_W            player top-left x
//  y_player   in   COORD_W            player top-left y
//  x_enemy    in   NUM_ENEMIES*COORD_W  enemy top-left x; enemy i is in slice [i*COORD_W +: COORD_W]
//  y_enemy    in   NUM_ENEMIES*COORD_W  enemy top-left y; same packing as x_enemy
//  enemy_en   in   NUM_ENEMIES        enemy i drawn and collidable only when bit i = 1
//  button     in   1                  raw, asynchronous, active-low push button
//  Red        out  COLOR_W            registered colour channel
//  Green      out  COLOR_W
//  Blue       out  COLOR_W
//  collision  out  1                  sticky hit flag
//  hit_index  out  $clog2(NUM_ENEMIES) (min 1)  index of the enemy hit first
//  game_state out  2                  encoding of state_t
//  led        out  1                  1 while in DEAD
// BEHAVIOUR
//  Reset (async, reset=0)
//   - state=IDLE; Red/Green/Blue=0; collision=0; hit_index=0; led=0; synchroniser and
//     one-shot flops cleared.
//   - Reset dominates every other event.
//  Button path
//   - Feed ~button through SYNC_STAGES flops, then a rising-edge detector.
//   - press = 1-cycle pulse, asserted SYNC_STAGES+1 cycles after the press.
//   - Holding the button gives exactly one pulse.
//  Hit tests
//   - All hit tests use strict bounds: px > x0 && px < x0+SPRITE_W, and likewise for y.
//   - Compute sums at COORD_W+1 bits so they cannot wrap.
//  Layer priority in PLAYING, highest first
//   1. player: yellow, with white inset 10 px on each side
//   2. lowest-index enabled enemy: black
//   3. ground bands: green
//   4. sky: COL_SKY
//  Collision
//   - Occurs in PLAYING when the current (x,y) is inside the player box and inside any
//     enabled enemy box.
//   - On the first such cycle: collision<=1, and hit_index<=lowest such index.
//   - Both then hold until the next IDLE entry.
//  State machine (state_t)
//   - IDLE    : full-screen yellow; black banner box, 320x60, centred in the active window.
//               press -> PLAYING.
//   - PLAYING : sprite render as above.
//               collision set -> DEAD on the cycle after it is set.
//               press is ignored.
//   - DEAD    : full-screen red; black banner box; led=1.
//               press -> IDLE; collision and hit_index are cleared on that transition.
//  Simultaneous events
//   - Collision and press in the same PLAYING cycle: collision wins.
//   - Disabled enemies never draw and never collide, even if the bit drops mid-frame.
//  Latency and blanking
//   - Colour is 1 cycle after (x,y).
//   - The in-window blank flag is registered alongside the colour, so outputs are 0 for
//     pixels outside the window with the same 1-cycle latency.
//   - Positions are sampled live; no frame buffering.
//  Colours
//   - Constants are COLOR_W wide, saturated: 4'hF, not 8-bit literals.
// STRUCTURE
//  Package game_pkg
//   - state_t enum {IDLE=2'd0, PLAYING=2'd1, DEAD=2'd2}.
//   - rgb_t struct of three COLOR_W fields.
//   - Colour constants: COL_YELLOW, COL_WHITE, COL_BLACK, COL_GREEN, COL_SKY, COL_RED.
//  Sub-module btn_oneshot
//   - Parameter SYNC_STAGES; ports clk, reset, button_n, press.
//  Top level
//   - Enemy hit vector from a generate loop, then a priority encoder.
//   - Next-state logic in always_comb; state and colour registers in always_ff.
// TESTING
//  1. Reset mid-PLAYING with collision=1
//     -> all outputs 0, game_state=0, next frame draws IDLE yellow.
//  2. IDLE, button low for 50 cycles
//     -> exactly one press; game_state=1 at cycle SYNC_STAGES+2.
//  3. Player (300,200), enemy2 (340,220) enabled, enemies 0/1 disabled and overlapping
//     -> collision=1, hit_index=2, DEAD next cycle, led=1.
//  4. Enemy touching edge only, x_enemy=x_player+60
//     -> no collision (strict bounds).
//  5. x_player=16'hFFE0
//     -> no false hit from wrap; pixel x=10 is not player-coloured.
//  6. Pixel (100,100) or (784,300)
//     -> RGB=0 one cycle later; (145,36) in PLAYING -> green band.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and colour constants for the VGA game renderer.
package game_pkg;

  localparam int COLOR_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DEAD    = 2'd2
  } state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  localparam rgb_t COL_YELLOW = '{r: '1, g: '1, b: '0};
  localparam rgb_t COL_WHITE  = '{r: '1, g: '1, b: '1};
  localparam rgb_t COL_BLACK  = '{r: '0, g: '0, b: '0};
  localparam rgb_t COL_GREEN  = '{r: '0, g: '1, b: '0};
  localparam rgb_t COL_SKY    = '{r: COLOR_W'(4), g: COLOR_W'(10), b: '1};
  localparam rgb_t COL_RED    = '{r: '1, g: '0, b: '0};

endpackage

// File: rtl/game_renderer_if.sv
// Pixel position, sprite positions, button and colour/status outputs of the renderer.
interface game_renderer_if #(
  parameter int COORD_W     = 16,
  parameter int NUM_ENEMIES = 4
);
  import game_pkg::*;

  localparam int HIW = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;

  logic [COORD_W-1:0]             x;
  logic [COORD_W-1:0]             y;
  logic [COORD_W-1:0]             x_player;
  logic [COORD_W-1:0]             y_player;
  logic [NUM_ENEMIES*COORD_W-1:0] x_enemy;
  logic [NUM_ENEMIES*COORD_W-1:0] y_enemy;
  logic [NUM_ENEMIES-1:0]         enemy_en;
  logic                           button;
  logic [COLOR_W-1:0]             Red;
  logic [COLOR_W-1:0]             Green;
  logic [COLOR_W-1:0]             Blue;
  logic                           collision;
  logic [HIW-1:0]                 hit_index;
  logic [1:0]                     game_state;
  logic                           led;

  modport master (
    output x, y, x_player, y_player, x_enemy, y_enemy, enemy_en, button,
    input  Red, Green, Blue, collision, hit_index, game_state, led
  );

  modport slave (
    input  x, y, x_player, y_player, x_enemy, y_enemy, enemy_en, button,
    output Red, Green, Blue, collision, hit_index, game_state, led
  );

endinterface

// File: rtl/btn_oneshot.sv
// Synchronises a raw active-low button and emits one registered pulse per press,
// SYNC_STAGES+1 cycles after the press is first sampled.
module btn_oneshot #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], ~button_n};
    prev_d  = sync_q[SYNC_STAGES-1];
    press_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_renderer.sv
// Per-pixel colour generator and IDLE/PLAYING/DEAD controller with pixel-accurate
// player/enemy collision; colour and blanking appear one cycle after (x,y).
module game_renderer
  import game_pkg::*;
#(
  parameter int COORD_W     = 16,
  parameter int NUM_ENEMIES = 4,
  parameter int SPRITE_W    = 60,
  parameter int SPRITE_H    = 60,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 783,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 514,
  parameter int GROUND_H    = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  game_renderer_if.slave  bus
);

  localparam int HIW   = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int INSET = 10;
  localparam int BAN_W = 320;
  localparam int BAN_H = 60;
  localparam int HC    = (H_ACT_START + H_ACT_END) / 2;
  localparam int VC    = (V_ACT_START + V_ACT_END) / 2;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   wide_t;

  localparam wide_t  SW  = wide_t'(SPRITE_W);
  localparam wide_t  SH  = wide_t'(SPRITE_H);
  localparam wide_t  INS = wide_t'(INSET);
  localparam coord_t HS  = coord_t'(H_ACT_START);
  localparam coord_t HE  = coord_t'(H_ACT_END);
  localparam coord_t VS  = coord_t'(V_ACT_START);
  localparam coord_t VE  = coord_t'(V_ACT_END);
  localparam coord_t GT  = coord_t'(V_ACT_START + GROUND_H);
  localparam coord_t GB  = coord_t'(V_ACT_END - GROUND_H);
  localparam coord_t BX0 = coord_t'(HC - BAN_W / 2);
  localparam coord_t BX1 = coord_t'(HC + BAN_W / 2);
  localparam coord_t BY0 = coord_t'(VC - BAN_H / 2);
  localparam coord_t BY1 = coord_t'(VC + BAN_H / 2);

  // Strict open interval (lo, lo+len), evaluated one bit wider so sprites near the top of the range cannot wrap.
  function automatic logic in_span(input coord_t p, input wide_t lo, input wide_t len);
    return ({1'b0, p} > lo) && ({1'b0, p} < lo + len);
  endfunction

  state_t           state_q, state_d;
  logic             collision_q, collision_d;
  logic [HIW-1:0]   hit_idx_q, hit_idx_d;
  rgb_t             colour_q, colour_d;
  logic             vis_q, vis_d;

  logic                   press;
  logic [NUM_ENEMIES-1:0] enemy_hit;
  logic                   enemy_any;
  logic [HIW-1:0]         hit_first;
  logic                   player_in, player_core;
  logic                   in_ground, in_banner;

  btn_oneshot #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
    .clk      (clk),
    .reset    (reset),
    .button_n (bus.button),
    .press    (press)
  );

  assign player_in   = in_span(bus.x, {1'b0, bus.x_player}, SW) &&
                       in_span(bus.y, {1'b0, bus.y_player}, SH);
  assign player_core = in_span(bus.x, {1'b0, bus.x_player} + INS, SW - (INS << 1)) &&
                       in_span(bus.y, {1'b0, bus.y_player} + INS, SH - (INS << 1));

  for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_enemy
    assign enemy_hit[i] = bus.enemy_en[i] &&
                          in_span(bus.x, {1'b0, bus.x_enemy[i*COORD_W +: COORD_W]}, SW) &&
                          in_span(bus.y, {1'b0, bus.y_enemy[i*COORD_W +: COORD_W]}, SH);
  end

  always_comb begin
    hit_first = '0;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (enemy_hit[i]) hit_first = HIW'(i);
    end
  end

  assign enemy_any = |enemy_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      collision_q <= 1'b0;
      hit_idx_q   <= '0;
      colour_q    <= COL_BLACK;
      vis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      collision_q <= collision_d;
      hit_idx_q   <= hit_idx_d;
      colour_q    <= colour_d;
      vis_q       <= vis_d;
    end
  end

  // Press is deliberately ignored while PLAYING; a latched hit ends the game next cycle.
  always_comb begin
    state_d     = state_q;
    collision_d = collision_q;
    hit_idx_d   = hit_idx_q;
    case (state_q)
      IDLE: begin
        if (press) state_d = PLAYING;
      end
      PLAYING: begin
        if (collision_q) begin
          state_d = DEAD;
        end else if (player_in && enemy_any) begin
          collision_d = 1'b1;
          hit_idx_d   = hit_first;
        end
      end
      DEAD: begin
        if (press) begin
          state_d     = IDLE;
          collision_d = 1'b0;
          hit_idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vis_d     = (bus.x > HS) && (bus.x <= HE) && (bus.y > VS) && (bus.y <= VE);
    in_ground = (bus.y <= GT) || (bus.y > GB);
    in_banner = (bus.x > BX0) && (bus.x <= BX1) && (bus.y > BY0) && (bus.y <= BY1);
    colour_d  = COL_BLACK;
    case (state_q)
      IDLE:    colour_d = in_banner ? COL_BLACK : COL_YELLOW;
      PLAYING: begin
        if (player_in)      colour_d = player_core ? COL_WHITE : COL_YELLOW;
        else if (enemy_any) colour_d = COL_BLACK;
        else if (in_ground) colour_d = COL_GREEN;
        else                colour_d = COL_SKY;
      end
      DEAD:    colour_d = in_banner ? COL_BLACK : COL_RED;
      default: colour_d = COL_BLACK;
    endcase
  end

  assign bus.Red        = vis_q ? colour_q.r : '0;
  assign bus.Green      = vis_q ? colour_q.g : '0;
  assign bus.Blue       = vis_q ? colour_q.b : '0;
  assign bus.collision  = collision_q;
  assign bus.hit_index  = hit_idx_q;
  assign bus.game_state = state_q;
  assign bus.led        = (state_q == DEAD);

endmodule

// File: tb/tb_game_renderer.sv
// Randomised and directed checks of game_renderer against a pixel-rule reference model.
module tb_game_renderer;

  localparam int S  = 2;
  localparam int NE = 4;

  logic clk = 1'b0;
  logic reset;

  game_renderer_if #(.COORD_W(16), .NUM_ENEMIES(NE)) bus ();

  game_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state (values the outputs should show after the latest edge)
  int          m_state;
  bit          m_coll;
  int          m_hidx;
  bit          m_press;
  bit          hist[0:7];
  logic [11:0] m_rgb;

  function automatic bit in_box(int px, int py, int x0, int y0, int m);
    return px > x0 + m && px < x0 + 60 - m && py > y0 + m && py < y0 + 60 - m;
  endfunction

  task automatic model_reset();
    m_state = 0; m_coll = 0; m_hidx = 0; m_press = 0; m_rgb = 12'h000;
    for (int i = 0; i < 8; i++) hist[i] = 1'b1;
  endtask

  task automatic model_edge();
    int px, py, plx, ply, first;
    bit pl, vis, ground, banner;
    logic [11:0] col;
    if (!reset) begin
      model_reset();
      return;
    end
    px = int'(bus.x); py = int'(bus.y);
    plx = int'(bus.x_player); ply = int'(bus.y_player);
    first = -1;
    for (int i = NE - 1; i >= 0; i--)
      if (bus.enemy_en[i] && in_box(px, py, int'(bus.x_enemy[i*16 +: 16]),
                                    int'(bus.y_enemy[i*16 +: 16]), 0)) first = i;
    pl     = in_box(px, py, plx, ply, 0);
    vis    = px >= 145 && px <= 783 && py >= 36 && py <= 514;
    ground = py <= 55 || py >= 495;
    banner = px >= 304 && px <= 623 && py >= 245 && py <= 304;
    case (m_state)
      0:       col = banner ? 12'h000 : 12'hFF0;
      1:       col = pl ? (in_box(px, py, plx, ply, 10) ? 12'hFFF : 12'hFF0)
                        : (first >= 0) ? 12'h000 : ground ? 12'h0F0 : 12'h4AF;
      default: col = banner ? 12'h000 : 12'hF00;
    endcase
    m_rgb = vis ? col : 12'h000;
    if (m_state == 0) begin
      if (m_press) m_state = 1;
    end else if (m_state == 1) begin
      if (m_coll) m_state = 2;
      else if (pl && first >= 0) begin m_coll = 1; m_hidx = first; end
    end else if (m_press) begin
      m_state = 0; m_coll = 0; m_hidx = 0;
    end
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = bus.button;
    m_press = !hist[S] && hist[S+1];
  endtask

  task automatic check_all();
    chk("rgb",   32'({bus.Red, bus.Green, bus.Blue}), 32'(m_rgb));
    chk("state", 32'(bus.game_state), 32'(m_state));
    chk("coll",  32'(bus.collision), 32'(m_coll));
    chk("hidx",  32'(bus.hit_index), 32'(m_hidx));
    chk("led",   32'(bus.led), 32'(m_state == 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pix(input int px, input int py);
    bus.x = 16'(px); bus.y = 16'(py);
  endtask

  task automatic set_enemy(input int i, input int ex, input int ey);
    bus.x_enemy[i*16 +: 16] = 16'(ex);
    bus.y_enemy[i*16 +: 16] = 16'(ey);
  endtask

  task automatic press_button();
    bus.button = 1'b0;
    repeat (S + 3) step();
    bus.button = 1'b1;
    repeat (S + 2) step();
  endtask

  function automatic logic [11:0] rgb_now();
    return {bus.Red, bus.Green, bus.Blue};
  endfunction

  initial begin
    reset = 1'b0;
    bus.button = 1'b1;
    bus.x = '0; bus.y = '0; bus.x_player = 16'd600; bus.y_player = 16'd400;
    bus.x_enemy = '0; bus.y_enemy = '0; bus.enemy_en = '0;
    model_reset();
    repeat (3) step();
    chk("reset_rgb",   32'(rgb_now()), 32'h0);
    chk("reset_state", 32'(bus.game_state), 32'h0);
    reset = 1'b1;

    // Held button: one press, PLAYING appears at cycle S+2 and stays
    pix(200, 300);
    bus.button = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (c == S + 1) chk("t2_still_idle", 32'(bus.game_state), 32'd0);
      if (c == S + 2) chk("t2_playing", 32'(bus.game_state), 32'd1);
    end
    chk("t2_one_press", 32'(bus.game_state), 32'd1);
    bus.button = 1'b1;
    repeat (4) step();

    // Blanking and window edges
    pix(100, 100); step(); chk("t6_blank_left", 32'(rgb_now()), 32'h0);
    pix(784, 300); step(); chk("t6_blank_right", 32'(rgb_now()), 32'h0);
    pix(145, 36);  step(); chk("t6_ground_top", 32'(rgb_now()), 32'h0F0);
    pix(783, 514); step(); chk("t6_ground_bot", 32'(rgb_now()), 32'h0F0);
    pix(146, 200); step(); chk("t6_sky", 32'(rgb_now()), 32'h4AF);

    // Edge-touching enemy never collides
    bus.x_player = 16'd300; bus.y_player = 16'd200;
    set_enemy(0, 360, 200); bus.enemy_en = 4'b0001;
    for (int px = 350; px <= 370; px++) begin pix(px, 230); step(); end
    chk("t4_no_touch_hit", 32'(bus.collision), 32'd0);

    // Player near the top of the coordinate range must not wrap onto small x
    bus.x_player = 16'hFFE0; set_enemy(0, 0, 200);
    for (int px = 0; px <= 20; px++) begin pix(px, 230); step(); end
    chk("t5_no_wrap_hit", 32'(bus.collision), 32'd0);
    bus.x_player = 16'hFFE0; set_enemy(0, 150, 200);
    pix(160, 230); step();
    chk("t5_enemy_black", 32'(rgb_now()), 32'h000);

    // Disabled overlapping enemies lose to enabled enemy 2
    pix(200, 100);
    bus.x_player = 16'd300; bus.y_player = 16'd200;
    set_enemy(0, 310, 210); set_enemy(1, 310, 210); set_enemy(2, 340, 220); set_enemy(3, 0, 0);
    bus.enemy_en = 4'b0100;
    step();
    pix(320, 215); step(); chk("t3_disabled_no_hit", 32'(bus.collision), 32'd0);
    pix(350, 230); step();
    chk("t3_coll", 32'(bus.collision), 32'd1);
    chk("t3_hidx", 32'(bus.hit_index), 32'd2);
    pix(200, 100); step();
    chk("t3_dead", 32'(bus.game_state), 32'd2);
    chk("t3_led", 32'(bus.led), 32'd1);
    step(); chk("t3_red", 32'(rgb_now()), 32'hF00);
    pix(400, 270); step(); chk("t3_banner", 32'(rgb_now()), 32'h000);

    // DEAD -> IDLE clears the hit; IDLE -> PLAYING; hit again then reset
    pix(200, 100);
    press_button();
    chk("dead_to_idle", 32'(bus.game_state), 32'd0);
    chk("idle_coll_clr", 32'(bus.collision), 32'd0);
    press_button();
    chk("idle_to_play", 32'(bus.game_state), 32'd1);
    pix(350, 230); step();
    chk("t1_pre_coll", 32'(bus.collision), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("t1_rst_rgb",   32'(rgb_now()), 32'h0);
    chk("t1_rst_state", 32'(bus.game_state), 32'd0);
    chk("t1_rst_coll",  32'(bus.collision), 32'd0);
    chk("t1_rst_hidx",  32'(bus.hit_index), 32'd0);
    chk("t1_rst_led",   32'(bus.led), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    pix(200, 100); step();
    chk("t1_idle_yellow", 32'(rgb_now()), 32'hFF0);

    // Random scenes around the player with random button activity
    for (int c = 0; c < 3000; c++) begin
      int plx, ply;
      if (c % 64 == 0) begin
        plx = int'($urandom_range(150, 700));
        ply = int'($urandom_range(40, 460));
        bus.x_player = ($urandom_range(0, 7) == 0) ? 16'(16'hFFC0 + $urandom_range(0, 63))
                                                   : 16'(plx);
        bus.y_player = 16'(ply);
        for (int i = 0; i < NE; i++)
          set_enemy(i, plx + int'($urandom_range(0, 180)) - 90,
                       ply + int'($urandom_range(0, 180)) - 90);
        bus.enemy_en = 4'($urandom_range(0, 15));
      end
      plx = int'(bus.x_player); ply = int'(bus.y_player);
      if ($urandom_range(0, 3) != 0)
        pix(plx + int'($urandom_range(0, 140)) - 70, ply + int'($urandom_range(0, 140)) - 70);
      else
        pix(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      if ($urandom_range(0, 15) == 0) bus.enemy_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) bus.button = ~bus.button;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
